// File: rtl/mem_addr_seq_pkg.sv
// Shared types and constants for the memory-address sequencer.
// Imported by the interface, the encoder and the top.
package mem_addr_seq_pkg;

    typedef enum logic [1:0] {
        NORM     = 2'd0,
        EXC_ADDR = 2'd1,
        EXC_HOLD = 2'd2
    } state_e;

    localparam int CAUSE_OPCODE = 0;
    localparam int CAUSE_OVF    = 1;
    localparam int CAUSE_DIV0   = 2;

    localparam int DEF_VEC_BASE = 253;
    localparam int CNT_W        = 4;

    // Index width that stays legal for single-entry sets.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_addr_seq_if.sv
// Datapath/control-unit bundle of the address sequencer.
// master = control/datapath side, slave = sequencer.
interface mem_addr_seq_if
    import mem_addr_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int NEXC  = 3
);
    localparam int SW = idx_w(NSRC);
    localparam int CW = idx_w(NEXC);

    logic [NSRC*WIDTH-1:0] src_data;
    logic [SW-1:0]         src_sel;
    logic                  load;
    logic [NEXC-1:0]       exc_req;
    logic                  exc_clr;
    logic [WIDTH-1:0]      addr_out;
    logic                  sel_err;
    logic                  exc_active;
    logic [CW-1:0]         exc_cause;
    logic                  exc_done;
    logic [NEXC-1:0]       pending;

    modport master (
        output src_data, src_sel, load, exc_req, exc_clr,
        input  addr_out, sel_err, exc_active, exc_cause,
        input  exc_done, pending
    );

    modport slave (
        input  src_data, src_sel, load, exc_req, exc_clr,
        output addr_out, sel_err, exc_active, exc_cause,
        output exc_done, pending
    );

endinterface

// File: rtl/mem_addr_seq_prio_enc.sv
// Lowest-index-wins priority encoder (bit0 highest priority).
// Shared with the interrupt logic.
module prio_enc
    import mem_addr_seq_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_addr_seq.sv
// Registered memory-address select with an exception-vector
// sequence (latch cause, drive vector address, hand back).
module mem_addr_seq
    import mem_addr_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NSRC     = 4,
    parameter int NEXC     = 3,
    parameter int VEC_BASE = DEF_VEC_BASE,
    parameter int MEM_LAT  = 1
) (
    input  logic           clk,
    input  logic           reset,
    mem_addr_seq_if.slave  bus
);

    localparam int CW = idx_w(NEXC);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic             serr_q, serr_d;
    logic [CW-1:0]    cause_q, cause_d;
    logic [NEXC-1:0]  pend_q, pend_d;

    logic [NEXC-1:0]  cand;
    logic [NEXC-1:0]  served;
    logic [CW-1:0]    enc_idx;
    logic             enc_vld;

    // Requests of this very cycle compete with latched ones.
    assign cand = pend_q | bus.exc_req;

    prio_enc #(.N(NEXC)) u_enc (
        .req   (cand),
        .idx   (enc_idx),
        .valid (enc_vld)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        serr_d  = 1'b0;
        cause_d = cause_q;
        served  = '0;
        unique case (state_q)
            NORM: begin
                if (enc_vld) begin
                    state_d = EXC_ADDR;
                    cause_d = enc_idx;
                    addr_d  = WIDTH'(VEC_BASE) + WIDTH'(enc_idx);
                    cnt_d   = CNT_W'(MEM_LAT - 1);
                    served  = NEXC'(1) << enc_idx;
                end else if (bus.load) begin
                    if (int'(bus.src_sel) < NSRC) begin
                        addr_d = bus.src_data[int'(bus.src_sel)*WIDTH +: WIDTH];
                    end else begin
                        serr_d = 1'b1;
                    end
                end
            end
            EXC_ADDR: begin
                if (cnt_q == '0) begin
                    state_d = EXC_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            EXC_HOLD: begin
                if (bus.exc_clr) begin
                    state_d = NORM;
                end
            end
            default: state_d = NORM;
        endcase
        pend_d = cand & ~served;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= NORM;
            cnt_q   <= '0;
            addr_q  <= '0;
            serr_q  <= 1'b0;
            cause_q <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            serr_q  <= serr_d;
            cause_q <= cause_d;
            pend_q  <= pend_d;
        end
    end

    assign bus.addr_out   = addr_q;
    assign bus.sel_err    = serr_q;
    assign bus.exc_active = (state_q != NORM);
    assign bus.exc_cause  = cause_q;
    assign bus.exc_done   = (state_q == EXC_ADDR) && (cnt_q == '0);
    assign bus.pending    = pend_q;

endmodule
